// File: rtl/lfsr_sequence_buffer.sv
// Captures a run of lfsr samples into a small memory and replays it over a valid/ready port.
// Optional macro SEQ_NO_REPEAT_EN: discard a fill sample equal to the previously stored one.
module lfsr_sequence_buffer #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 4,
   parameter int LEN_W  = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] rnd,
   input  logic              gen,
   input  logic [LEN_W-1:0]  len,
   input  logic              play,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic              seq_ready,
   output logic              busy,
   output logic [LEN_W-1:0]  count
);
   // state   | meaning
   // S_IDLE  | nothing stored, waiting for gen
   // S_FILL  | capturing samples from rnd until target reached
   // S_READY | complete sequence stored, waiting for gen or play
   // S_PLAY  | replaying stored sequence over the output handshake
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY, S_PLAY} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LEN_W-1:0]  target_q, target_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              mem_we;
   logic              accept;
   logic [LEN_W-1:0]  len_clamped;
   logic [LEN_W-1:0]  rd_nxt;

`ifdef SEQ_NO_REPEAT_EN
   logic [DATA_W-1:0] prev_q, prev_d;

   assign accept = (wr_ptr_q == '0) || (rnd != prev_q);

   always_comb begin
      prev_d = prev_q;
      if (mem_we) prev_d = rnd;
   end

   always_ff @(posedge clock) begin
      if (reset) prev_q <= '0;
      else       prev_q <= prev_d;
   end
`else
   assign accept = 1'b1;
`endif

   always_comb begin
      len_clamped = len;
      if (len == '0)                    len_clamped = LEN_W'(1);
      else if (len > LEN_W'(DEPTH))     len_clamped = LEN_W'(DEPTH);
   end

   assign rd_nxt = rd_ptr_q + LEN_W'(1);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      target_d    = target_q;
      count_d     = count_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      mem_we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (gen) begin
               state_d  = S_FILL;
               target_d = len_clamped;
               wr_ptr_d = '0;
               count_d  = '0;
            end
         end
         S_FILL: begin
            if (accept) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + LEN_W'(1);
               if (wr_ptr_d == target_q) begin
                  state_d = S_READY;
                  count_d = target_q;
               end
            end
         end
         S_READY: begin
            // gen has priority over a simultaneous play
            if (gen) begin
               state_d  = S_FILL;
               target_d = len_clamped;
               wr_ptr_d = '0;
               count_d  = '0;
            end else if (play) begin
               state_d     = S_PLAY;
               rd_ptr_d    = '0;
               out_valid_d = 1'b1;
               out_data_d  = mem_q[0];
               out_last_d  = (count_q == LEN_W'(1));
            end
         end
         S_PLAY: begin
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = S_READY;
               end else begin
                  rd_ptr_d   = rd_nxt;
                  out_data_d = mem_q[rd_nxt[AW-1:0]];
                  out_last_d = (rd_nxt == (count_q - LEN_W'(1)));
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         target_q    <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         target_q    <= target_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // Memory is never cleared; stale contents are unreachable while count is 0.
   always_ff @(posedge clock) begin
      if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= rnd;
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign count     = count_q;
   assign seq_ready = (state_q == S_READY);
   assign busy      = (state_q == S_FILL) || (state_q == S_PLAY);

endmodule

// File: tb/tb_lfsr_sequence_buffer.sv
// Bench for lfsr_sequence_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_lfsr_sequence_buffer;
   localparam int DEPTH = 8;
`ifdef SEQ_NO_REPEAT_EN
   localparam bit NR = 1'b1;
`else
   localparam bit NR = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] rnd = '0;
   logic       gen = 1'b0;
   logic [4:0] len = '0;
   logic       play = 1'b0;
   logic       out_ready = 1'b1;
   logic [3:0] out_data;
   logic       out_valid, out_last, seq_ready, busy;
   logic [4:0] count;

   int checks = 0;
   int errors = 0;

   lfsr_sequence_buffer #(.DEPTH(DEPTH), .DATA_W(4), .LEN_W(5)) dut (
      .clock(clock), .reset(reset), .rnd(rnd), .gen(gen), .len(len), .play(play),
      .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .seq_ready(seq_ready), .busy(busy), .count(count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: 0 idle, 1 capturing, 2 stored, 3 replaying
   int         m_mode = 0;
   logic [3:0] m_seq[$];
   logic [3:0] m_fill[$];
   int         m_tgt = 0, m_idx = 0, m_cnt = 0;
   bit         m_ov = 0, m_ol = 0, m_on = 0;
   logic [3:0] m_od = '0;

   function automatic void start_fill(input int l);
      m_tgt  = (l == 0) ? 1 : ((l > DEPTH) ? DEPTH : l);
      m_fill.delete();
      m_cnt  = 0;
      m_mode = 1;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_mode = 0; m_cnt = 0; m_ov = 0; m_ol = 0; m_od = '0; m_on = 1;
      end else if (m_on) begin
         case (m_mode)
            0: if (gen) start_fill(int'(len));
            1: begin
               if (m_fill.size() == 0 || !NR || rnd != m_fill[m_fill.size()-1])
                  m_fill.push_back(rnd);
               if (m_fill.size() == m_tgt) begin
                  m_seq  = m_fill;
                  m_cnt  = m_tgt;
                  m_mode = 2;
               end
            end
            2: begin
               if (gen) start_fill(int'(len));
               else if (play) begin
                  m_mode = 3; m_idx = 0; m_ov = 1; m_od = m_seq[0];
                  m_ol = (m_seq.size() == 1);
               end
            end
            default: begin
               if (m_ov && out_ready) begin
                  if (m_idx == m_seq.size() - 1) begin
                     m_ov = 0; m_ol = 0; m_mode = 2;
                  end else begin
                     m_idx++;
                     m_od = m_seq[m_idx];
                     m_ol = (m_idx == m_seq.size() - 1);
                  end
               end
            end
         endcase
      end
   end

   always @(negedge clock) begin
      if (m_on) begin
         chk("m_out_valid", out_valid, m_ov);
         chk("m_out_last", out_last, m_ol);
         chk("m_out_data", out_data, m_od);
         chk("m_seq_ready", seq_ready, m_mode == 2);
         chk("m_busy", busy, m_mode == 1 || m_mode == 3);
         chk("m_count", count, m_cnt);
      end
   end

   logic [3:0] got[$];
   logic [3:0] exp_q[$];

   task automatic play_capture(input int stall_at, input int stall_n, input logic [3:0] stall_exp);
      int left;
      bit done;
      left = stall_n;
      done = 0;
      got.delete();
      @(negedge clock); play = 1; out_ready = 1;
      @(negedge clock); play = 0;
      for (int c = 0; c < 64 && !done; c++) begin
         if (out_valid) begin
            if (got.size() == stall_at && left > 0) begin
               chk("stall_data", out_data, stall_exp);
               out_ready = 0;
               left--;
            end else begin
               out_ready = 1;
               got.push_back(out_data);
               if (out_last) done = 1;
            end
         end
         @(negedge clock);
      end
      out_ready = 1;
      chk("play_done", done, 1);
      chk("after_play_valid", out_valid, 0);
      chk("after_play_ready", seq_ready, 1);
   endtask

   task automatic check_seq(input string nm);
      chk({nm, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk({nm, "_elem"}, got[i], exp_q[i]);
   endtask

   task automatic gen_fill(input logic [4:0] l, input int n, input logic [3:0] v0, input logic [3:0] v1,
                           input logic [3:0] v2, input logic [3:0] v3, input logic [3:0] v4);
      logic [3:0] vals [5];
      vals = '{v0, v1, v2, v3, v4};
      @(negedge clock); gen = 1; len = l;
      @(negedge clock); gen = 0;
      for (int i = 0; i < n; i++) begin
         rnd = vals[i];
         @(negedge clock);
      end
   endtask

   initial begin
      @(negedge clock);
      @(negedge clock);
      reset = 0;
      chk("rst_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_seq_ready", seq_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", out_data, 0);

      // 1: basic capture and replay
      gen_fill(5'd4, 4, 4'h9, 4'h4, 4'h2, 4'hB, 4'h0);
      chk("t1_count", count, 4);
      chk("t1_seq_ready", seq_ready, 1);
      exp_q = '{4'h9, 4'h4, 4'h2, 4'hB};
      play_capture(-1, 0, 4'h0);
      check_seq("t1_play");

      // 2: stall on second element, then replay again
      play_capture(1, 3, 4'h4);
      check_seq("t2_stall");
      play_capture(-1, 0, 4'h0);
      check_seq("t2_again");

      // 3: length clamps
      gen_fill(5'd0, 1, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("t3_count1", count, 1);
      exp_q = '{4'h6};
      play_capture(-1, 0, 4'h0);
      check_seq("t3_single");
      @(negedge clock); gen = 1; len = 5'd12;
      @(negedge clock); gen = 0;
      for (int i = 0; i < 8; i++) begin
         rnd = 4'(i);
         @(negedge clock);
      end
      chk("t3_count8", count, 8);
      chk("t3_ready8", seq_ready, 1);

      // 4: reset mid-replay
      @(negedge clock); play = 1; out_ready = 1;
      @(negedge clock); play = 0;
      @(negedge clock);
      @(negedge clock); reset = 1;
      @(negedge clock); reset = 0;
      chk("t4_valid", out_valid, 0);
      chk("t4_count", count, 0);
      chk("t4_seq_ready", seq_ready, 0);
      play = 1;
      @(negedge clock); play = 0;
      chk("t4_play_ign", out_valid, 0);
      @(negedge clock);
      chk("t4_play_ign2", out_valid, 0);

      // 5: gen beats play; play during fill ignored
      gen_fill(5'd2, 2, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0);
      chk("t5_pre_ready", seq_ready, 1);
      gen = 1; play = 1; len = 5'd3;
      @(negedge clock); gen = 0;
      chk("t5_busy", busy, 1);
      chk("t5_novalid", out_valid, 0);
      rnd = 4'h1;
      @(negedge clock); play = 0; rnd = 4'h2;
      @(negedge clock); rnd = 4'h3;
      @(negedge clock);
      chk("t5_ready", seq_ready, 1);
      chk("t5_novalid2", out_valid, 0);

      // 6: repeat filtering
      gen_fill(5'd3, 5, 4'h5, 4'h5, 4'h7, 4'h7, 4'h3);
      chk("t6_ready", seq_ready, 1);
      chk("t6_count", count, 3);
      if (NR) exp_q = '{4'h5, 4'h7, 4'h3};
      else    exp_q = '{4'h5, 4'h5, 4'h7};
      play_capture(-1, 0, 4'h0);
      check_seq("t6_stored");

      // random traffic, checked by the model every cycle
      for (int c = 0; c < 4000; c++) begin
         reset     = ($urandom_range(0, 199) == 0);
         gen       = ($urandom_range(0, 29) == 0);
         play      = ($urandom_range(0, 9) == 0);
         len       = 5'($urandom_range(0, 31));
         rnd       = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
      end
      reset = 0; gen = 0; play = 0; out_ready = 1;
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
